// File: rtl/shift_issue_stage_pkg.sv
// Shared definitions for the shift issue stage: shift-kind encodings, MIPS
// R-type opcode/funct constants, the buffered entry layout and the
// occupancy states of the 2-entry output buffer.
package shift_issue_stage_pkg;

  // Shift kind as presented to the shifter.
  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_RSVD = 2'b11
  } shift_op_e;

  localparam logic [5:0] OPC_RTYPE  = 6'b000000;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  // One buffered operation: value to shift, amount, kind, illegal flag.
  typedef struct packed {
    logic [31:0] rt;
    logic [4:0]  shamt;
    shift_op_e   op;
    logic        illegal;
  } shift_entry_t;

  localparam int ENTRY_W = 32 + 5 + 2 + 1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_FULL  = 2'b10
  } occ_state_e;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of a MIPS R-type shift instruction into a buffer entry.
// Ports:
//   opcode_i    instr[31:26]
//   funct_i     instr[5:0]
//   shamt_imm_i instr[10:6] (immediate shift amount)
//   rs_shamt_i  rs[4:0]     (variable shift amount)
//   rt_val_i    value to shift
//   entry_o     decoded {rt, shamt, op, illegal}
module shift_decode
  import shift_issue_stage_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  input  logic [4:0]   shamt_imm_i,
  input  logic [4:0]   rs_shamt_i,
  input  logic [31:0]  rt_val_i,
  output shift_entry_t entry_o
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // field unassigned, which would otherwise infer a latch.
    entry_o.rt      = rt_val_i;
    entry_o.shamt   = 5'd0;
    entry_o.op      = SHIFT_SLL;
    entry_o.illegal = 1'b1;

    if (opcode_i == OPC_RTYPE) begin
      case (funct_i)
        FUNCT_SLL:  begin entry_o.op = SHIFT_SLL; entry_o.shamt = shamt_imm_i; entry_o.illegal = 1'b0; end
        FUNCT_SRL:  begin entry_o.op = SHIFT_SRL; entry_o.shamt = shamt_imm_i; entry_o.illegal = 1'b0; end
        FUNCT_SRA:  begin entry_o.op = SHIFT_SRA; entry_o.shamt = shamt_imm_i; entry_o.illegal = 1'b0; end
        FUNCT_SLLV: begin entry_o.op = SHIFT_SLL; entry_o.shamt = rs_shamt_i;  entry_o.illegal = 1'b0; end
        FUNCT_SRLV: begin entry_o.op = SHIFT_SRL; entry_o.shamt = rs_shamt_i;  entry_o.illegal = 1'b0; end
        FUNCT_SRAV: begin entry_o.op = SHIFT_SRA; entry_o.shamt = rs_shamt_i;  entry_o.illegal = 1'b0; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_issue_stage.sv
// Registered issue stage feeding the sll/srl/sra shifters. Decodes an R-type
// shift, buffers {rt, shamt, op, illegal} in a 2-entry FIFO and counts
// completed output handshakes.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  synchronous clear of buffered entries
//   in_valid/in_ready      upstream handshake (in_ready is registered)
//   in_instr/rs_val/rt_val instruction word and register operands
//   out_valid/out_ready    downstream handshake
//   out_rt/shamt/op/illegal head entry fields
//   issue_count            wrapping count of output handshakes
module shift_issue_stage
  import shift_issue_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs_val,
  input  logic [31:0]      in_rt_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_rt,
  output logic [4:0]       out_shamt,
  output logic [1:0]       out_op,
  output logic             out_illegal,
  output logic [CNT_W-1:0] issue_count
);

  occ_state_e         state_q, state_d;
  logic [ENTRY_W-1:0] entry0_q;   // head
  logic [ENTRY_W-1:0] entry1_q;   // second-oldest, valid only when FULL
  logic [CNT_W-1:0]   issue_count_q;
  shift_entry_t       new_entry;
  shift_entry_t       head;
  logic               push, pop;

  // Only the low rs bits and the opcode/shamt/funct fields matter here.
  logic unused_bits;
  assign unused_bits = ^{in_instr[25:11], in_rs_val[31:5]};

  shift_decode u_decode (
    .opcode_i    (in_instr[31:26]),
    .funct_i     (in_instr[5:0]),
    .shamt_imm_i (in_instr[10:6]),
    .rs_shamt_i  (in_rs_val[4:0]),
    .rt_val_i    (in_rt_val),
    .entry_o     (new_entry)
  );

  // Both handshake qualifiers come from registered state only, so there is
  // no combinational path from out_ready to in_ready.
  assign in_ready  = (state_q != OCC_FULL);
  assign out_valid = (state_q != OCC_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (push) state_d = OCC_ONE;
        OCC_ONE: begin
          if (push && !pop)      state_d = OCC_FULL;
          else if (pop && !push) state_d = OCC_EMPTY;
        end
        OCC_FULL:  if (pop) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= OCC_EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: the two buffer entries are reset even though validity lives in
  // state_q, because the head is visible on the outputs and must read zero
  // out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
    end else if (!flush) begin
      case (state_q)
        OCC_EMPTY: if (push) entry0_q <= new_entry;
        OCC_ONE: begin
          // push+pop replaces the head in place; push alone fills slot 1.
          if (push && pop) entry0_q <= new_entry;
          else if (push)   entry1_q <= new_entry;
        end
        OCC_FULL:  if (pop) entry0_q <= entry1_q;
        default: ;
      endcase
    end
  end

  // A pop in a flush cycle is a completed handshake and still counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   issue_count_q <= '0;
    else if (pop) issue_count_q <= issue_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign head        = shift_entry_t'(entry0_q);
  assign out_rt      = head.rt;
  assign out_shamt   = head.shamt;
  assign out_op      = head.op;
  assign out_illegal = head.illegal;
  assign issue_count = issue_count_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_rs_val = '0;
  logic [31:0] in_rt_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_rt;
  logic [4:0]  out_shamt;
  logic [1:0]  out_op;
  logic        out_illegal;
  logic [3:0]  issue_count;

  shift_issue_stage #(.CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_rs_val   (in_rs_val),
    .in_rt_val   (in_rt_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rt      (out_rt),
    .out_shamt   (out_shamt),
    .out_op      (out_op),
    .out_illegal (out_illegal),
    .issue_count (issue_count)
  );

  always #5 clk = ~clk;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [39:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] ent(input logic [31:0] rt, input logic [4:0] sh,
                                      input logic [1:0] op, input logic ill);
    return {rt, sh, op, ill};
  endfunction

  // Scoreboard monitor: outputs are sampled on the falling edge, the
  // handshake completes on the following rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected output: got %h with empty scoreboard",
                 {out_rt, out_shamt, out_op, out_illegal});
      end else begin
        check("scoreboard entry", {24'b0, out_rt, out_shamt, out_op, out_illegal},
              {24'b0, exp_q.pop_front()});
      end
    end
  end

  // Present one instruction until accepted; the expected entry is queued at
  // the falling edge that sees in_ready high.
  task automatic send(input logic [31:0] instr, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [39:0] exp);
    in_instr  = instr;
    in_rs_val = rs;
    in_rt_val = rt;
    in_valid  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_vec++;
    n_miss++;
    $display("FAIL send timeout: instr %h never accepted", instr);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    n_vec++;
    n_miss++;
    $display("FAIL drain timeout: %0d entries outstanding", exp_q.size());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    check("reset in_ready",    in_ready,    1);
    check("reset out_valid",   out_valid,   0);
    check("reset out_rt",      out_rt,      0);
    check("reset out_shamt",   out_shamt,   0);
    check("reset out_op",      out_op,      0);
    check("reset out_illegal", out_illegal, 0);
    check("reset issue_count", issue_count, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back decode vectors with out_ready held high
    out_ready = 1'b1;
    send(32'h00094043, 32'h0, 32'h8000FFFF, ent(32'h8000FFFF, 5'd1, 2'b10, 1'b0));   // sra 1
    check("latency out_valid", out_valid, 1);
    send(32'h01494007, 32'hFFFFFFE3, 32'h87FFFFE0, ent(32'h87FFFFE0, 5'd3, 2'b10, 1'b0)); // srav
    send(32'h01494004, 32'h00000025, 32'h00000001, ent(32'h00000001, 5'd5, 2'b00, 1'b0)); // sllv
    send(32'h01494006, 32'h0000003F, 32'hF0000000, ent(32'hF0000000, 5'd31, 2'b01, 1'b0)); // srlv
    send(32'h8D090000, 32'h00000000, 32'h12345678, ent(32'h12345678, 5'd0, 2'b00, 1'b1)); // lw
    send(32'h00094041, 32'h00000000, 32'hCAFEBABE, ent(32'hCAFEBABE, 5'd0, 2'b00, 1'b1)); // funct 1
    wait_drain();
    check("count after stream", issue_count, 6);
    check("idle out_valid",     out_valid,   0);

    // Backpressure: two accepted, third held
    out_ready = 1'b0;
    send(32'h000947C0, 32'h0, 32'hA5A5A5A5, ent(32'hA5A5A5A5, 5'd31, 2'b00, 1'b0)); // sll 31
    send(32'h000947C2, 32'h0, 32'h0F0F0F0F, ent(32'h0F0F0F0F, 5'd31, 2'b01, 1'b0)); // srl 31
    check("bp in_ready low",  in_ready,  0);
    check("bp out_valid",     out_valid, 1);
    in_instr  = 32'h000947C3;
    in_rt_val = 32'h80000001;
    in_valid  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("bp in_ready held", in_ready,    0);
    check("bp count stalled", issue_count, 6);
    out_ready = 1'b1;
    send(32'h000947C3, 32'h0, 32'h80000001, ent(32'h80000001, 5'd31, 2'b10, 1'b0)); // sra 31
    wait_drain();
    check("bp count", issue_count, 9);

    // Flush with a full buffer and a simultaneous in_valid
    out_ready = 1'b0;
    send(32'h00094080, 32'h0, 32'h11111111, ent(32'h11111111, 5'd2, 2'b00, 1'b0));
    send(32'h000940C2, 32'h0, 32'h22222222, ent(32'h22222222, 5'd3, 2'b01, 1'b0));
    in_instr = 32'h00094103; in_rt_val = 32'h33333333; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    check("flush full out_valid", out_valid,   0);
    check("flush full in_ready",  in_ready,    1);
    check("flush full count",     issue_count, 9);

    // Flush with one entry, a pop and a push in the same cycle
    send(32'h00094140, 32'h0, 32'h44444444, ent(32'h44444444, 5'd5, 2'b00, 1'b0));
    in_instr = 32'h00094182; in_rt_val = 32'h55555555; in_valid = 1'b1;
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush pop out_valid", out_valid,    0);
    check("flush pop count",     issue_count,  10);
    @(posedge clk);
    #1;
    check("flush push dropped",  out_valid,    0);
    check("flush scoreboard",    exp_q.size(), 0);

    // Reset mid-stall with two entries buffered
    out_ready = 1'b0;
    send(32'h000941C0, 32'h0, 32'h66666666, ent(32'h66666666, 5'd7, 2'b00, 1'b0));
    send(32'h00094202, 32'h0, 32'h77777777, ent(32'h77777777, 5'd8, 2'b01, 1'b0));
    #2 rst_n = 1'b0;
    #1;
    check("mid reset out_valid", out_valid,   0);
    check("mid reset in_ready",  in_ready,    1);
    check("mid reset out_rt",    out_rt,      0);
    check("mid reset count",     issue_count, 0);
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post reset out_valid", out_valid, 0);

    // Counter wrap with CNT_W = 4
    for (int i = 0; i < 15; i++) begin
      logic [31:0] rs = 32'(i) + 32'h100;
      send(32'h01494004, rs, 32'(i), ent(32'(i), rs[4:0], 2'b00, 1'b0));
    end
    wait_drain();
    check("count before wrap", issue_count, 15);
    send(32'h01494006, 32'hFFFFFFFF, 32'hDEADBEEF, ent(32'hDEADBEEF, 5'd31, 2'b01, 1'b0));
    wait_drain();
    check("count wrap", issue_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
# shift_issue_stage

Registered issue stage directly upstream of the combinational shifters (sll/srl/sra). It accepts a MIPS R-type instruction word with its register operands over a valid/ready handshake and decodes the shift function. It selects the shift amount (immediate shamt field or rs[4:0]) and presents the operand value, shift amount and shift kind to the shifter through a 2-entry output buffer. Non-shift or non-R-type words are flagged illegal and passed through so downstream logic can trap.

## Interface
- CNT_W, 16, width of the issued-operation counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of buffered entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept; registered
- in_instr  in  32  instruction word
- in_rs_val  in  32  rs register value (variable shifts)
- in_rt_val  in  32  rt register value (value to shift)
- out_valid  out  1  head entry valid
- out_ready  in  1  shifter/downstream accepts
- out_rt  out  32  value to shift
- out_shamt  out  5  shift amount, unsigned 0..31
- out_op  out  2  00 sll, 01 srl, 10 sra, 11 unused
- out_illegal  out  1  entry is not a supported shift
- issue_count  out  CNT_W  count of completed output handshakes

## Operation
- Decode: opcode = in_instr[31:26], funct = in_instr[5:0], shamt_imm = in_instr[10:6].
- Supported only when opcode = 0: funct 000000 sll, 000010 srl, 000011 sra use shamt_imm; 000100 sllv, 000110 srlv, 000111 srav use in_rs_val[4:0] (upper rs bits ignored).
- Any other opcode/funct: out_illegal=1, out_op=00, out_shamt=0, out_rt=in_rt_val.
- Buffer: 2-entry FIFO of {rt, shamt, op, illegal}; push on in_valid&&in_ready, pop on out_valid&&out_ready.
- Occupancy FSM: EMPTY -> ONE on push; ONE -> FULL on push without pop; ONE -> EMPTY on pop without push; ONE stays ONE on push+pop; FULL -> ONE on pop (no push possible when FULL).
- in_ready = (state != FULL), from registered state only; no combinational path out_ready -> in_ready.
- out_valid = (state != EMPTY); outputs reflect head entry, held stable while out_valid && !out_ready.
- issue_count increments by 1 per output handshake, wraps 2^CNT_W-1 -> 0; flush does not clear it.
- flush: state -> EMPTY next cycle; any push in the flush cycle is dropped; a pop in the flush cycle still counts in issue_count.

## Timing
- Reset (async assert, sync release): state EMPTY, in_ready=1, out_valid=0, out_rt=0, out_shamt=0, out_op=00, out_illegal=0, issue_count=0.
- Latency: input handshake in cycle N -> out_valid=1 with that entry in cycle N+1 (when buffer was EMPTY).
- Throughput: 1 op/cycle with out_ready held high.
- Under backpressure: accepts exactly 2 entries, in_ready low from the cycle after the second push until a pop.
- Order strictly FIFO; no entry lost or duplicated across stall/release.
- Reset mid-operation: buffered entries discarded, counter cleared, no output handshake completes in the reset cycle.

## Structure
- Shared package: op encodings (SHIFT_SLL/SRL/SRA), funct constants (6-bit, all six shift functs), opcode RTYPE=0, entry struct/bit-layout width (32+5+2+1=40).
- One sub-module: shift_decode (combinational instr/rs/rt -> entry fields); FIFO, FSM and counter live in shift_issue_stage.

## Test plan
- sra: in_instr=0x00094043, in_rt_val=0x8000FFFF, out_ready=1 -> next cycle out_rt=0x8000FFFF, out_shamt=1, out_op=10, out_illegal=0, issue_count=1.
- srav: in_instr=0x01494007, in_rs_val=0xFFFFFFE3, in_rt_val=0x87FFFFE0 -> out_shamt=3, out_op=10 (upper rs bits ignored).
- Backpressure: out_ready=0, push sll/srl/sra with shamt 31 -> first two accepted, in_ready=0, third held; release out_ready -> all three emerge in order, issue_count=3.
- Illegal: in_instr=0x8D090000 (lw) and 0x00094041 (funct 1) -> out_illegal=1, out_op=00, out_shamt=0, out_rt=in_rt_val.
- Flush with FULL buffer and simultaneous in_valid -> next cycle out_valid=0, in_ready=1, pushed entry absent; issue_count unchanged unless pop occurred.
- Assert rst_n low with 2 entries buffered mid-stall -> outputs immediately at reset values, issue_count=0; counter wrap with CNT_W=4 after 16 pops -> 0.
